seq_addsub: RTL and testbench

Parametrised multi-cycle add/subtract unit, the successor to the 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands, CHUNK bits per clock, through a CHUNK-bit ripple slice; the carry is registered between slices.
- Valid/ready handshakes on input and output.
- Reports sum/difference, carry-out and signed overflow.
- Sits between operand registers and the result bus wherever area matters more than single-cycle latency.

---
 rtl/seq_addsub_pkg.sv | 19 +
 rtl/seq_addsub_if.sv | 25 ++
 rtl/seq_addsub_rca_chunk.sv | 40 ++++
 rtl/seq_addsub.sv | 93 +++++++++
 tb/tb_seq_addsub.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_addsub_pkg.sv
// Shared types and sizing helpers for the chunked sequential add/subtract unit.
package seq_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int numChunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk configuration still needs a one-bit counter to stay legal.
  function automatic int cntWidth(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/seq_addsub_if.sv
// Operand/result handshake bundle for seq_addsub.
interface seq_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_valid, x, y, sub, out_ready,
    input  in_ready, s, co, ovf, out_valid
  );

  modport slave (
    input  in_valid, x, y, sub, out_ready,
    output in_ready, s, co, ovf, out_valid
  );
endinterface

// File: rtl/seq_addsub_rca_chunk.sv
// CHUNK-bit ripple-carry slice built from full-adder cells; exposes the carry
// into its top bit so the caller can derive signed overflow.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);
  logic [CHUNK:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < CHUNK; i++) begin : gen_fa
    fa_cell u_fa (
      .a    (x[i]),
      .b    (y[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  assign co    = c[CHUNK];
  assign c_msb = c[CHUNK-1];
endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle add/subtract: one CHUNK-wide ripple slice reused NCH times with
// the carry held in a register between passes.
module seq_addsub
  import seq_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic         clk,
  input logic         rst,
  seq_addsub_if.slave bus
);
  localparam int NCH  = numChunks(WIDTH, CHUNK);
  localparam int CNTW = cntWidth(NCH);

  state_e            state_q;
  logic [CNTW-1:0]   count_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  s_q;
  logic              carry_q;
  logic              co_q;
  logic              ovf_q;

  logic [CHUNK-1:0]  sliceA;
  logic [CHUNK-1:0]  sliceB;
  logic [CHUNK-1:0]  sliceSum;
  logic              sliceCo;
  logic              sliceCmsb;

  always_comb begin
    sliceA = a_q[count_q*CHUNK +: CHUNK];
    sliceB = b_q[count_q*CHUNK +: CHUNK];
  end

  rca_chunk #(.CHUNK(CHUNK)) u_slice (
    .x     (sliceA),
    .y     (sliceB),
    .ci    (carry_q),
    .s     (sliceSum),
    .co    (sliceCo),
    .c_msb (sliceCmsb)
  );

  // Subtraction is folded in at accept time: b is stored inverted and the
  // initial carry is 1, so RUN never needs to know the mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.x;
            b_q     <= bus.y ^ {WIDTH{bus.sub}};
            carry_q <= bus.sub;
            count_q <= '0;
            s_q     <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          s_q[count_q*CHUNK +: CHUNK] <= sliceSum;
          carry_q                     <= sliceCo;
          if (count_q == CNTW'(NCH - 1)) begin
            co_q    <= sliceCo;
            ovf_q   <= sliceCmsb ^ sliceCo;
            state_q <= DONE;
          end else begin
            count_q <= count_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.s         = s_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
endmodule

// File: tb/tb_seq_addsub.sv
// Scoreboard bench for seq_addsub: directed cases on CHUNK=4 plus random
// sweeps on CHUNK=16 and CHUNK=1 instances sharing the same stimulus drivers.
module tb_seq_addsub;
  localparam int WIDTH = 16;

  typedef struct packed {
    logic             ovf;
    logic             co;
    logic [WIDTH-1:0] s;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [WIDTH-1:0] xDrv = '0;
  logic [WIDTH-1:0] yDrv = '0;
  logic             subDrv = 1'b0;
  logic             outReadyDrv = 1'b0;
  logic [2:0]       inValidDrv = '0;
  int               sel = 0;

  int checks = 0;
  int failures = 0;
  res_t sb[$];

  seq_addsub_if #(.WIDTH(WIDTH)) bus4 ();
  seq_addsub_if #(.WIDTH(WIDTH)) bus16 ();
  seq_addsub_if #(.WIDTH(WIDTH)) bus1 ();

  assign bus4.x = xDrv;   assign bus4.y = yDrv;   assign bus4.sub = subDrv;
  assign bus16.x = xDrv;  assign bus16.y = yDrv;  assign bus16.sub = subDrv;
  assign bus1.x = xDrv;   assign bus1.y = yDrv;   assign bus1.sub = subDrv;
  assign bus4.out_ready = outReadyDrv;
  assign bus16.out_ready = outReadyDrv;
  assign bus1.out_ready = outReadyDrv;
  assign bus4.in_valid = inValidDrv[0];
  assign bus16.in_valid = inValidDrv[1];
  assign bus1.in_valid = inValidDrv[2];

  seq_addsub #(.WIDTH(WIDTH), .CHUNK(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  seq_addsub #(.WIDTH(WIDTH), .CHUNK(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
  seq_addsub #(.WIDTH(WIDTH), .CHUNK(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));

  logic             oValid;
  logic             iReady;
  logic [WIDTH-1:0] oS;
  logic             oCo;
  logic             oOvf;

  always_comb begin
    oValid = bus4.out_valid; iReady = bus4.in_ready;
    oS = bus4.s; oCo = bus4.co; oOvf = bus4.ovf;
    case (sel)
      1: begin
        oValid = bus16.out_valid; iReady = bus16.in_ready;
        oS = bus16.s; oCo = bus16.co; oOvf = bus16.ovf;
      end
      2: begin
        oValid = bus1.out_valid; iReady = bus1.in_ready;
        oS = bus1.s; oCo = bus1.co; oOvf = bus1.ovf;
      end
      default: ;
    endcase
  end

  // Reference: full-width arithmetic with overflow from operand/result signs.
  function automatic res_t refModel(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                                    input logic sv);
    logic [WIDTH:0] full;
    res_t r;
    if (!sv) full = {1'b0, xv} + {1'b0, yv};
    else     full = {1'b0, xv} + {1'b0, ~yv} + 17'd1;
    r.s  = full[WIDTH-1:0];
    r.co = full[WIDTH];
    if (!sv) r.ovf = (xv[WIDTH-1] == yv[WIDTH-1]) && (r.s[WIDTH-1] != xv[WIDTH-1]);
    else     r.ovf = (xv[WIDTH-1] != yv[WIDTH-1]) && (r.s[WIDTH-1] != xv[WIDTH-1]);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%h expected=%h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Presents one operand set to the selected instance and returns #1 after the
  // accept edge, with the model result queued.
  task automatic applyStimulus(input logic [WIDTH-1:0] xv, input logic [WIDTH-1:0] yv,
                               input logic sv);
    int n = 0;
    while (!iReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!iReady) checkOutput("in_ready_timeout", 32'(iReady), 32'd1);
    xDrv = xv; yDrv = yv; subDrv = sv;
    inValidDrv[sel] = 1'b1;
    sb.push_back(refModel(xv, yv, sv));
    @(posedge clk);
    #1;
    inValidDrv[sel] = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int expLat);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!oValid && n < 200);
    checkOutput({tag, "_latency"}, 32'(n), 32'(expLat));
  endtask

  task automatic checkResult(input string tag);
    res_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb[0];
    checkOutput({tag, "_s"}, 32'(oS), 32'(e.s));
    checkOutput({tag, "_co"}, 32'(oCo), 32'(e.co));
    checkOutput({tag, "_ovf"}, 32'(oOvf), 32'(e.ovf));
  endtask

  task automatic releaseResult(input string tag);
    outReadyDrv = 1'b1;
    @(posedge clk);
    #1;
    outReadyDrv = 1'b0;
    if (sb.size() > 0) void'(sb.pop_front());
    checkOutput({tag, "_valid_drop"}, 32'(oValid), 32'd0);
  endtask

  task automatic runOp(input string tag, input logic [WIDTH-1:0] xv,
                       input logic [WIDTH-1:0] yv, input logic sv, input int lat);
    applyStimulus(xv, yv, sv);
    waitValid(tag, lat);
    checkResult(tag);
    releaseResult(tag);
  endtask

  initial begin
    res_t held;
    sel = 0;
    repeat (2) @(negedge clk);
    checkOutput("rst_s", 32'(oS), 32'd0);
    checkOutput("rst_co", 32'(oCo), 32'd0);
    checkOutput("rst_ovf", 32'(oOvf), 32'd0);
    checkOutput("rst_out_valid", 32'(oValid), 32'd0);
    checkOutput("rst_in_ready", 32'(iReady), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    runOp("add_small", 16'h000B, 16'h000D, 1'b0, 4);
    runOp("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 4);
    runOp("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 4);
    runOp("sub_neg", 16'h0005, 16'h0007, 1'b1, 4);
    runOp("sub_ovf", 16'h8000, 16'h0001, 1'b1, 4);

    // Backpressure with fresh operands waiting on in_valid.
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    waitValid("bp", 4);
    held = refModel(16'h1234, 16'h4321, 1'b0);
    xDrv = 16'hA5A5; yDrv = 16'h0F0F; subDrv = 1'b1;
    inValidDrv[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_hold_valid", 32'(oValid), 32'd1);
      checkOutput("bp_hold_s", 32'(oS), 32'(held.s));
      checkOutput("bp_hold_flags", 32'({oCo, oOvf}), 32'({held.co, held.ovf}));
      checkOutput("bp_in_ready", 32'(iReady), 32'd0);
    end
    outReadyDrv = 1'b1;
    @(posedge clk);
    #1;
    outReadyDrv = 1'b0;
    void'(sb.pop_front());
    checkOutput("bp_release_valid", 32'(oValid), 32'd0);
    checkOutput("bp_release_in_ready", 32'(iReady), 32'd1);
    sb.push_back(refModel(16'hA5A5, 16'h0F0F, 1'b1));
    @(posedge clk);
    #1;
    inValidDrv[0] = 1'b0;
    checkOutput("bp_accept_in_ready", 32'(iReady), 32'd0);
    waitValid("bp_next", 4);
    checkResult("bp_next");
    releaseResult("bp_next");

    // Leave co/ovf set, then abort a run midway with an async reset.
    runOp("pre_abort", 16'h8000, 16'h0001, 1'b1, 4);
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("abort_s", 32'(oS), 32'd0);
    checkOutput("abort_flags", 32'({oCo, oOvf}), 32'd0);
    checkOutput("abort_out_valid", 32'(oValid), 32'd0);
    checkOutput("abort_in_ready", 32'(iReady), 32'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    runOp("post_abort", 16'h1357, 16'h2468, 1'b1, 4);

    sel = 1;
    for (int i = 0; i < 1000; i++)
      runOp("c16_rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1);

    sel = 2;
    for (int i = 0; i < 1000; i++)
      runOp("c1_rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
